// File: rtl/dmem_access_ctrl_if.sv
// Requester-side bundle for dmem_access_ctrl.
// Requesters use master; the controller uses slave.
interface dmem_access_ctrl_if #(
  parameter int WIDTH_ADDR = 32,
  parameter int Data_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [WIDTH_ADDR-1:0] addr;
  logic [1:0]            size;
  logic                  unsigned_ld;
  logic [Data_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  done;
  logic [Data_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, size, unsigned_ld, wdata,
    input  gnt, done, rdata, err
  );

  modport slave (
    input  req, we, addr, size, unsigned_ld, wdata,
    output gnt, done, rdata, err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin front end for a word-wide single-port data memory.
// Handles alignment/range checks, sub-word RMW stores and load extension.
module dmem_access_ctrl #(
  parameter int WIDTH_ADDR = 32,
  parameter int Data_WIDTH = 32,
  parameter int MEM_DEPTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_ctrl_if.slave     p0,
  dmem_access_ctrl_if.slave     p1,
  output logic                  mem_we,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic [Data_WIDTH-1:0] mem_wdata,
  input  logic [Data_WIDTH-1:0] mem_rdata
);
  localparam int DW = Data_WIDTH;
  localparam logic [WIDTH_ADDR:0] LIMIT =
    (WIDTH_ADDR+1)'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {
    IDLE, RD, RD_WAIT, WR, RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [15:0] wd16;
  } req_t;

  state_t                state;
  req_t                  cur;
  logic                  owner;
  logic                  last_grant;
  logic                  we_q;
  logic [1:0]            done_q;
  logic [DW-1:0]         rdata_q;
  logic                  err_q;

  logic                  win0, win1;
  logic                  sel_we, sel_uns, bad;
  logic [WIDTH_ADDR-1:0] sel_addr, sel_idx;
  logic [1:0]            sel_size;
  logic [DW-1:0]         sel_wdata;
  logic [DW-1:0]         ext, merged;

  function automatic logic [DW-1:0] extend(
    input logic [DW-1:0] w,
    input logic [1:0]    off,
    input logic [1:0]    size,
    input logic          uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    extend = {{(DW-8){b[7] & ~uns}}, b};
      2'd1:    extend = {{(DW-16){h[15] & ~uns}}, h};
      default: extend = w;
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] w,
    input logic [1:0]    off,
    input logic [1:0]    size,
    input logic [15:0]   wd
  );
    merge = w;
    if (size == 2'd0)
      merge[{off, 3'b000} +: 8] = wd[7:0];
    else
      merge[{off[1], 4'b0000} +: 16] = wd;
  endfunction

  // Ties go to the port that did not win last time.
  assign win0 = p0.req & (~p1.req | last_grant);
  assign win1 = p1.req & (~p0.req | ~last_grant);

  always_comb begin
    sel_we    = win1 ? p1.we          : p0.we;
    sel_addr  = win1 ? p1.addr        : p0.addr;
    sel_size  = win1 ? p1.size        : p0.size;
    sel_uns   = win1 ? p1.unsigned_ld : p0.unsigned_ld;
    sel_wdata = win1 ? p1.wdata       : p0.wdata;
  end

  assign sel_idx = {2'b00, sel_addr[WIDTH_ADDR-1:2]};

  assign bad = (sel_size == 2'd3)
             | ((sel_size == 2'd1) & sel_addr[0])
             | ((sel_size == 2'd2) & (sel_addr[1:0] != 2'b00))
             | ({1'b0, sel_addr} >= LIMIT);

  assign ext    = extend(mem_rdata, cur.off, cur.size, cur.uns);
  assign merged = merge(mem_rdata, cur.off, cur.size, cur.wd16);

  assign p0.gnt   = ~rst & (state == IDLE) & win0;
  assign p1.gnt   = ~rst & (state == IDLE) & win1;
  assign p0.done  = done_q[0];
  assign p1.done  = done_q[1];
  assign p0.rdata = rdata_q & {DW{done_q[0]}};
  assign p1.rdata = rdata_q & {DW{done_q[1]}};
  assign p0.err   = err_q & done_q[0];
  assign p1.err   = err_q & done_q[1];

  // A write pending in WR is dropped the moment rst rises.
  assign mem_we = we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win0 | win1) begin
            owner      <= win1;
            last_grant <= win1;
            cur        <= '{we:   sel_we,
                            off:  sel_addr[1:0],
                            size: sel_size,
                            uns:  sel_uns,
                            wd16: sel_wdata[15:0]};
            if (bad) begin
              done_q  <= {win1, ~win1};
              err_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else if (sel_we && sel_size == 2'd2) begin
              we_q      <= 1'b1;
              mem_addr  <= sel_idx;
              mem_wdata <= sel_wdata;
              state     <= WR;
            end else begin
              mem_addr <= sel_idx;
              state    <= RD;
            end
          end
        end
        RD: state <= RD_WAIT;
        RD_WAIT: begin
          if (cur.we) begin
            we_q      <= 1'b1;
            mem_wdata <= merged;
            state     <= WR;
          end else begin
            mem_addr <= '0;
            rdata_q  <= ext;
            err_q    <= 1'b0;
            done_q   <= {owner, ~owner};
            state    <= RESP;
          end
        end
        WR: begin
          we_q      <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          rdata_q   <= '0;
          err_q     <= 1'b0;
          done_q    <= {owner, ~owner};
          state     <= RESP;
        end
        RESP: begin
          done_q  <= '0;
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl.
// Word-wide memory model, one-cycle read latency.
module tb_dmem_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_access_ctrl_if #(.WIDTH_ADDR(32), .Data_WIDTH(32)) p0_if ();
  dmem_access_ctrl_if #(.WIDTH_ADDR(32), .Data_WIDTH(32)) p1_if ();

  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [32];

  dmem_access_ctrl #(
    .WIDTH_ADDR(32), .Data_WIDTH(32), .MEM_DEPTH(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p0        (p0_if),
    .p1        (p1_if),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[4:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[4:0]];
  end

  int errors = 0;
  int checks = 0;

  int we_cnt = 0, g1_cnt = 0, d0_cnt = 0, d1_cnt = 0;
  int viol = 0;
  bit pend = 0, log_g = 0;
  logic [31:0] last_wa = '0;
  int gseq[$];

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      last_wa = mem_addr;
    end
    if (p1_if.gnt) g1_cnt++;
    if (p0_if.done) d0_cnt++;
    if (p1_if.done) d1_cnt++;
    if (p0_if.gnt || p1_if.gnt) begin
      if (pend) viol++;
      pend = 1;
      if (log_g) gseq.push_back(p1_if.gnt ? 1 : 0);
    end
    if (p0_if.done || p1_if.done) pend = 0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wd);
    if (port) begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr;
      p1_if.size = size; p1_if.unsigned_ld = uns; p1_if.wdata = wd;
    end else begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr;
      p0_if.size = size; p0_if.unsigned_ld = uns; p0_if.wdata = wd;
    end
  endtask

  function automatic logic gnt_of(input bit port);
    return port ? p1_if.gnt : p0_if.gnt;
  endfunction

  function automatic logic done_of(input bit port);
    return port ? p1_if.done : p0_if.done;
  endfunction

  task automatic xfer(input bit port, input bit we,
                      input logic [31:0] addr, input logic [1:0] size,
                      input bit uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int wn);
    drive(port, 1, we, addr, size, uns, wd);
    wn = 0;
    @(negedge clk);
    while (!gnt_of(port) && wn < 20) begin
      @(negedge clk);
      wn++;
    end
    @(posedge clk);
    #1 drive(port, 0, 0, '0, 2'd0, 0, '0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_of(port) && lat < 20);
    rd = port ? p1_if.rdata : p0_if.rdata;
    er = port ? p1_if.err : p0_if.err;
  endtask

  task automatic run(input string tag, input bit port, input bit we,
                     input logic [31:0] addr, input logic [1:0] size,
                     input bit uns, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat, wn;
    xfer(port, we, addr, size, uns, wd, rd, er, lat, wn);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, wn, we0, d0, g1, d1, n;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    drive(0, 0, 0, '0, 2'd0, 0, '0);
    drive(1, 0, 0, '0, 2'd0, 0, '0);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {p1_if.gnt, p0_if.gnt}, 0);
    chk("rst_done", {p1_if.done, p0_if.done}, 0);
    chk("rst_rdata", p0_if.rdata | p1_if.rdata, 0);
    chk("rst_err", {p1_if.err, p0_if.err}, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1 rst = 0;

    run("sw8", 0, 1, 32'h8, 2'd2, 0, 32'hDEADBEEF, 0, 0, 2);
    chk("sw8_we_addr", last_wa, 2);
    chk("sw8_mem", mem[2], 32'hDEADBEEF);
    run("lw8", 0, 0, 32'h8, 2'd2, 0, 0, 32'hDEADBEEF, 0, 3);
    run("sb9", 1, 1, 32'h9, 2'd0, 0, 32'hAA, 0, 0, 4);
    chk("sb9_mem", mem[2], 32'hDEADAAEF);
    run("lb9", 1, 0, 32'h9, 2'd0, 0, 0, 32'hFFFFFFAA, 0, 3);
    run("lbu9", 1, 0, 32'h9, 2'd0, 1, 0, 32'h000000AA, 0, 3);
    run("lhA", 0, 0, 32'hA, 2'd1, 0, 0, 32'hFFFFDEAD, 0, 3);
    run("lhuA", 0, 0, 32'hA, 2'd1, 1, 0, 32'h0000DEAD, 0, 3);

    we0 = we_cnt;
    run("lw6", 0, 0, 32'h6, 2'd2, 0, 0, 0, 1, 1);
    run("sh3", 1, 1, 32'h3, 2'd1, 0, 32'h1234, 0, 1, 1);
    run("size3", 0, 1, 32'h0, 2'd3, 0, 32'h55, 0, 1, 1);
    run("lw80", 1, 0, 32'h80, 2'd2, 0, 0, 0, 1, 1);
    chk("err_no_we", we_cnt - we0, 0);

    run("sw4", 0, 1, 32'h4, 2'd2, 0, 32'h11223344, 0, 0, 2);
    d0 = d0_cnt;
    @(posedge clk);
    #1 drive(0, 1, 1, 32'h4, 2'd0, 0, 32'h55);
    @(negedge clk);
    chk("rmw_gnt", p0_if.gnt, 1);
    @(posedge clk);
    #1 drive(0, 0, 0, '0, 2'd0, 0, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("rst_wr_mem_we", mem_we, 0);
    @(posedge clk);
    #1 rst = 0;
    xfer(0, 0, 32'h4, 2'd2, 0, 0, rd, er, lat, wn);
    chk("after_rst_idle", wn, 0);
    chk("after_rst_lw4", rd, 32'h11223344);
    chk("no_abort_done", d0_cnt - d0, 1);

    g1 = g1_cnt;
    d1 = d1_cnt;
    @(posedge clk);
    #1 drive(0, 1, 0, 32'h8, 2'd2, 0, 0);
    @(negedge clk);
    chk("own_gnt", p0_if.gnt, 1);
    @(posedge clk);
    #1 begin
      drive(0, 0, 0, '0, 2'd0, 0, '0);
      drive(1, 1, 0, 32'h0, 2'd2, 0, 0);
    end
    @(negedge clk);
    chk("pulse_no_gnt", p1_if.gnt, 0);
    @(posedge clk);
    #1 drive(1, 0, 0, '0, 2'd0, 0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!p0_if.done && n < 20);
    chk("own_rdata", p0_if.rdata, 32'hDEADAAEF);
    @(posedge clk);
    chk("pulse_gnt_cnt", g1_cnt - g1, 0);
    chk("pulse_done_cnt", d1_cnt - d1, 0);
    #1 xfer(1, 0, 32'h8, 2'd2, 0, 0, rd, er, lat, wn);
    chk("p1_alone_wait", wn, 0);
    chk("p1_alone_rdata", rd, 32'hDEADAAEF);

    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 begin
      rst = 0;
      viol = 0;
      pend = 0;
      gseq.delete();
      log_g = 1;
      drive(0, 1, 0, 32'h0, 2'd2, 0, 0);
      drive(1, 1, 0, 32'h0, 2'd2, 0, 0);
    end
    repeat (17) @(negedge clk);
    #1 begin
      log_g = 0;
      drive(0, 0, 0, '0, 2'd0, 0, '0);
      drive(1, 0, 0, '0, 2'd0, 0, '0);
    end
    repeat (6) @(posedge clk);
    chk("rr_count_ge4", gseq.size() >= 4 ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i < gseq.size()) ? gseq[i] : -1;
      chk($sformatf("rr_grant%0d", i), g, i % 2);
    end
    chk("rr_one_in_flight", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
